// File: rtl/jy_irq_timer.sv
// Multi-channel JY-style IRQ prescaler/counter engine with per-channel pending flags and acknowledge.
// Optional feature macro JY_IRQ_RELOAD_EN: the pend-setting carry reloads ctr from a per-channel rl register.
module jy_irq_timer #(
  parameter int CHANNELS    = 2,
  parameter int CTR_W       = 8,
  parameter int PRE_W       = 8,
  parameter int PRE_SMALL_W = 3
) (
  input  logic                clk,
  input  logic                map_rst_n,
  input  logic                cpu_m2,
  input  logic                cpu_rw,
  input  logic                ppu_a12,
  input  logic                ppu_oe,
  input  logic                reg_we,
  input  logic [1:0]          reg_ch,
  input  logic [2:0]          reg_addr,
  input  logic [7:0]          reg_din,
  output logic                irq,
  output logic [CHANNELS-1:0] pend,
  output logic [CTR_W-1:0]    ctr_mon
);

  localparam logic [PRE_W-1:0] SMALL_MASK = PRE_W'((1 << PRE_SMALL_W) - 1);

  logic [2:0] m2_hist_q, m2_hist_d;
  logic [2:0] a12_hist_q, a12_hist_d;
  logic [3:0] oe_hist_q, oe_hist_d;
  logic [2:0] rw_hist_q, rw_hist_d;
  logic [3:0] edge_vec;

  logic [CHANNELS-1:0] en_q, en_d;
  logic [CHANNELS-1:0] en_dly_q, en_dly_d;
  logic [CHANNELS-1:0] pend_q, pend_d;
  logic                irq_q, irq_d;
  // Only the mode bits that matter are kept: {dir[1:0], small, src[1:0]}.
  logic [4:0]          mode_q [CHANNELS];
  logic [4:0]          mode_d [CHANNELS];
  logic [PRE_W-1:0]    pre_q  [CHANNELS];
  logic [PRE_W-1:0]    pre_d  [CHANNELS];
  logic [CTR_W-1:0]    ctr_q  [CHANNELS];
  logic [CTR_W-1:0]    ctr_d  [CHANNELS];
  logic [7:0]          xor_q  [CHANNELS];
  logic [7:0]          xor_d  [CHANNELS];
`ifdef JY_IRQ_RELOAD_EN
  logic [CTR_W-1:0]    rl_q   [CHANNELS];
  logic [CTR_W-1:0]    rl_d   [CHANNELS];
`endif

  logic             wr, wr_clobber, ack, tick, pend_set;
  logic [7:0]       din_x;
  logic [PRE_W-1:0] pmask, pre_inc, pre_dec;
  logic [CTR_W-1:0] ctr_lo_wr, ctr_hi_wr;

  always_comb begin
    m2_hist_d  = {m2_hist_q[1:0], cpu_m2};
    a12_hist_d = {a12_hist_q[1:0], ppu_a12};
    oe_hist_d  = {oe_hist_q[2:0], ppu_oe};
    rw_hist_d  = {rw_hist_q[1:0], cpu_rw};
  end

  // Oldest sample sits in the MSB, so each pattern reads left to right in time.
  assign edge_vec = {rw_hist_q == 3'b100, oe_hist_q == 4'b1000,
                     a12_hist_q == 3'b001, m2_hist_q == 3'b011};

  always_comb begin
    en_d       = en_q;
    en_dly_d   = en_q;
    pend_d     = pend_q;
    mode_d     = mode_q;
    pre_d      = pre_q;
    ctr_d      = ctr_q;
    xor_d      = xor_q;
`ifdef JY_IRQ_RELOAD_EN
    rl_d       = rl_q;
`endif
    wr         = 1'b0;
    wr_clobber = 1'b0;
    ack        = 1'b0;
    tick       = 1'b0;
    pend_set   = 1'b0;
    din_x      = '0;
    pmask      = '0;
    pre_inc    = '0;
    pre_dec    = '0;
    ctr_lo_wr  = '0;
    ctr_hi_wr  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      wr         = reg_we && (reg_ch == 2'(i));
      din_x      = reg_din ^ xor_q[i];
      wr_clobber = wr && ((reg_addr == 3'd4) || (reg_addr == 3'd5) ||
                          ((reg_addr == 3'd7) && (CTR_W > 8)));
      ack        = wr && (reg_addr == 3'd7) && reg_din[7];
      pmask      = mode_q[i][2] ? SMALL_MASK : '1;
      pre_inc    = pre_q[i] + PRE_W'(1);
      pre_dec    = pre_q[i] - PRE_W'(1);
      ctr_lo_wr  = (ctr_q[i] & ~CTR_W'(8'hFF)) | CTR_W'(din_x);
      ctr_hi_wr  = CTR_W'({din_x, ctr_q[i][7:0]});
      tick       = en_q[i] && edge_vec[mode_q[i][1:0]] && !wr_clobber;
      pend_set   = 1'b0;
      if (en_dly_q[i] && !en_q[i]) begin
        pre_d[i]  = '0;
        pend_d[i] = 1'b0;
      end else begin
        if (tick && (mode_q[i][4:3] == 2'd1)) begin
          pre_d[i] = pre_inc;
          if ((pre_inc & pmask) == '0) begin
            ctr_d[i] = ctr_q[i] + CTR_W'(1);
            if (ctr_q[i] == '1) begin
              pend_set = 1'b1;
`ifdef JY_IRQ_RELOAD_EN
              ctr_d[i] = rl_q[i];
`endif
            end
          end
        end else if (tick && (mode_q[i][4:3] == 2'd2)) begin
          pre_d[i] = pre_dec;
          if ((pre_dec & pmask) == pmask) begin
            ctr_d[i] = ctr_q[i] - CTR_W'(1);
            if (ctr_q[i] == '0) begin
              pend_set = 1'b1;
`ifdef JY_IRQ_RELOAD_EN
              ctr_d[i] = rl_q[i];
`endif
            end
          end
        end
        if (wr) begin
          case (reg_addr)
            3'd0: en_d[i] = reg_din[0];
            3'd1: mode_d[i] = {reg_din[7:6], reg_din[2:0]};
            3'd2: en_d[i] = 1'b0;
            3'd3: en_d[i] = 1'b1;
            3'd4: pre_d[i] = din_x[PRE_W-1:0];
            3'd5: ctr_d[i] = ctr_lo_wr;
            3'd6: xor_d[i] = reg_din;
            3'd7: if (CTR_W > 8) ctr_d[i] = ctr_hi_wr;
            default: ;
          endcase
        end
`ifdef JY_IRQ_RELOAD_EN
        if (wr && (reg_addr == 3'd5)) rl_d[i] = ctr_lo_wr;
        if (wr && (reg_addr == 3'd7)) rl_d[i] = ctr_hi_wr;
`endif
        // A carry landing in the same cycle as an acknowledge keeps the flag set.
        pend_d[i] = pend_set | (pend_q[i] & ~ack);
      end
    end
    irq_d = |pend_d;
  end

  always_ff @(posedge clk or negedge map_rst_n) begin
    if (!map_rst_n) begin
      m2_hist_q  <= '0;
      a12_hist_q <= '0;
      oe_hist_q  <= '0;
      rw_hist_q  <= '0;
      en_q       <= '0;
      en_dly_q   <= '0;
      pend_q     <= '0;
      irq_q      <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        mode_q[i] <= '0;
        pre_q[i]  <= '0;
        ctr_q[i]  <= '0;
        xor_q[i]  <= '0;
`ifdef JY_IRQ_RELOAD_EN
        rl_q[i]   <= '0;
`endif
      end
    end else begin
      m2_hist_q  <= m2_hist_d;
      a12_hist_q <= a12_hist_d;
      oe_hist_q  <= oe_hist_d;
      rw_hist_q  <= rw_hist_d;
      en_q       <= en_d;
      en_dly_q   <= en_dly_d;
      pend_q     <= pend_d;
      irq_q      <= irq_d;
      mode_q     <= mode_d;
      pre_q      <= pre_d;
      ctr_q      <= ctr_d;
      xor_q      <= xor_d;
`ifdef JY_IRQ_RELOAD_EN
      rl_q       <= rl_d;
`endif
    end
  end

  always_comb begin
    ctr_mon = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (reg_ch == 2'(i)) ctr_mon = ctr_q[i];
    end
  end

  assign irq  = irq_q;
  assign pend = pend_q;

endmodule
